// File: rtl/lcd_pkg.sv
// Shared HD44780 command constants, FSM state encoding and init-sequence helpers
// for the LCD bus scheduler.
package lcd_pkg;

    localparam logic [7:0] FUNC_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY_INC = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] HOME      = 8'h02;

    localparam logic [2:0] INIT_LEN  = 3'd4;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_SETUP = 3'd3,
        S_EN_HI = 3'd4,
        S_HOLD  = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = FUNC_8B2L;
            3'd1:    init_rom = DISP_ON;
            3'd2:    init_rom = ENTRY_INC;
            default: init_rom = CLEAR;
        endcase
    endfunction

    // Clear and return-home (01..03 with rs=0) need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CLEAR || data == HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-port round-robin grant for the LCD bus; the last-grant pointer moves only
// when a grant is actually accepted.
module lcd_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    // last = 1 means port 1 won most recently, so port 0 is favoured next.
    logic last;

    assign grant0 = valid0 & (~valid1 | last);
    assign grant1 = valid1 & (~valid0 | ~last);

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant1;
        end
    end

endmodule

// File: rtl/lcd_bus_sched.sv
// HD44780 8-bit bus owner: power-up wait, fixed init sequence, then arbitrated
// byte writes from two requesters with en strobe timing and execution waits.
module lcd_bus_sched
    import lcd_pkg::*;
#(
    parameter int T_SETUP    = 4,
    parameter int T_EN_HIGH  = 25,
    parameter int T_CMD_WAIT = 2000,
    parameter int T_CLR_WAIT = 82000,
    parameter int T_PWRUP    = 750000,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rs,
    output logic       en,
    output logic       wr,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       init_idx, init_idx_next;
    logic             init_done_q, init_done_next;
    logic             rs_q, rs_next;
    logic [7:0]       data_q, data_next;
    logic             grant0, grant1, accept;

    lcd_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Handshake: a byte transfers on a cycle where valid & ready are both high;
    // ready is combinational, at most one port is ready at a time, and the
    // requester keeps valid/rs/data steady until that cycle.
    assign req0_ready = (state == S_IDLE) & init_done_q & grant0;
    assign req1_ready = (state == S_IDLE) & init_done_q & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign en        = (state == S_EN_HI);
    assign busy      = (state != S_IDLE);
    assign wr        = 1'b0;
    assign rs        = rs_q;
    assign lcd_data  = data_q;
    assign init_done = init_done_q;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        init_idx_next  = init_idx;
        init_done_next = init_done_q;
        rs_next        = rs_q;
        data_next      = data_q;
        case (state)
            S_PWRUP: begin
                if (cnt == '0) state_next = S_INIT;
                else           cnt_next   = cnt - CNT_ONE;
            end
            S_INIT: begin
                rs_next       = 1'b0;
                data_next     = init_rom(init_idx);
                init_idx_next = init_idx + 3'd1;
                cnt_next      = LD_SETUP;
                state_next    = S_SETUP;
            end
            S_IDLE: begin
                if (accept) begin
                    rs_next    = grant0 ? req0_rs   : req1_rs;
                    data_next  = grant0 ? req0_data : req1_data;
                    cnt_next   = LD_SETUP;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    cnt_next   = LD_EN;
                    state_next = S_EN_HI;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_EN_HI: begin
                if (cnt == '0) state_next = S_HOLD;
                else           cnt_next   = cnt - CNT_ONE;
            end
            S_HOLD: begin
                cnt_next   = is_slow_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end else if (init_done_q) begin
                    state_next = S_IDLE;
                end else if (init_idx == INIT_LEN) begin
                    init_done_next = 1'b1;
                    state_next     = S_IDLE;
                end else begin
                    state_next = S_INIT;
                end
            end
            default: begin
                cnt_next   = LD_PWRUP;
                state_next = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_PWRUP;
            cnt         <= LD_PWRUP;
            init_idx    <= 3'd0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            init_idx    <= init_idx_next;
            init_done_q <= init_done_next;
            rs_q        <= rs_next;
            data_q      <= data_next;
        end
    end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Self-checking bench for lcd_bus_sched: a timestamp-based model of bus
// occupancy predicts every output each cycle; en pulses are scoreboarded.
module tb_lcd_bus_sched;

    localparam int TS = 2;
    localparam int TE = 3;
    localparam int TW = 10;
    localparam int TC = 40;
    localparam int TP = 20;
    localparam int BUDGET = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rs, req1_valid, req1_rs;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       rs, en, wr, busy, init_done;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_bus_sched #(
        .T_SETUP    (TS),
        .T_EN_HIGH  (TE),
        .T_CMD_WAIT (TW),
        .T_CLR_WAIT (TC),
        .T_PWRUP    (TP),
        .CNT_W      (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rs         (rs),
        .en         (en),
        .wr         (wr),
        .lcd_data   (lcd_data),
        .busy       (busy),
        .init_done  (init_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [8:0] exp_q [$];
    int         acc_port_q [$];
    bit         have_reset = 0;
    int         now = 0;
    bit         m_init_done, m_loaded;
    int         m_init_cnt, m_L, m_F, m_last;
    logic       m_rs, m_disp_rs;
    logic [7:0] m_data, m_disp_data;
    // en pulse monitor
    logic       prev_en;
    int         rise_cyc, last_rise, first_rise, pulse_cnt, init_done_cyc;
    logic [8:0] cap;

    function automatic void m_load(input logic r, input logic [7:0] d);
        m_L      = now;
        m_F      = now + TS + TE + 2 + ((!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? TC : TW);
        m_rs     = r;
        m_data   = d;
        m_loaded = 1;
        exp_q.push_back({r, d});
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            have_reset    = 1;
            now           = 0;
            m_init_done   = 0;
            m_init_cnt    = 0;
            m_loaded      = 0;
            m_L           = 0;
            m_F           = 0;
            m_last        = 1;
            m_disp_rs     = 0;
            m_disp_data   = 8'h00;
            prev_en       = 0;
            pulse_cnt     = 0;
            first_rise    = -1;
            init_done_cyc = -1;
            exp_q.delete();
        end else begin
            now++;
        end
    end

    always @(negedge clk) begin
        if (have_reset) begin
            bit idle, w0, w1, exp_en;
            if (!m_init_done) begin
                if (m_init_cnt == 0 && now == TP) begin
                    m_load(1'b0, rom[0]);
                    m_init_cnt = 1;
                end else if (m_init_cnt >= 1 && m_init_cnt <= 3 && now == m_F) begin
                    m_load(1'b0, rom[m_init_cnt]);
                    m_init_cnt++;
                end else if (m_init_cnt == 4 && now == m_F) begin
                    m_init_done = 1;
                end
            end
            if (m_loaded && now == m_L + 1) begin
                m_disp_rs   = m_rs;
                m_disp_data = m_data;
            end
            idle   = m_init_done && now >= m_F;
            w0     = req0_valid && (!req1_valid || m_last == 1);
            w1     = req1_valid && (!req0_valid || m_last == 0);
            exp_en = m_loaded && now >= m_L + 1 + TS && now <= m_L + TS + TE;

            chk("en", en, exp_en);
            chk("busy", busy, !idle);
            chk("init_done", init_done, m_init_done);
            chk("wr", wr, 1'b0);
            chk("rs", rs, m_disp_rs);
            chk("lcd_data", lcd_data, m_disp_data);
            chk("req0_ready", req0_ready, idle && w0);
            chk("req1_ready", req1_ready, idle && w1);

            if (en === 1'b1 && !prev_en) begin
                rise_cyc  = now;
                last_rise = now;
                cap       = {rs, lcd_data};
                if (first_rise < 0) first_rise = now;
            end
            if (en !== 1'b1 && prev_en) begin
                chk("en_width", now - rise_cyc, TE);
                if (exp_q.size() == 0) begin
                    chk("pulse_expected", exp_q.size(), 1);
                end else begin
                    chk("pulse_byte", cap, exp_q.pop_front());
                end
                pulse_cnt++;
            end
            prev_en = (en === 1'b1);
            if (init_done === 1'b1 && init_done_cyc < 0) init_done_cyc = now;

            if (idle && (w0 || w1)) begin
                if (w0) m_load(req0_rs, req0_data);
                else    m_load(req1_rs, req1_data);
                m_last = w1 ? 1 : 0;
                acc_port_q.push_back(w1 ? 1 : 0);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int p, input logic r, input logic [7:0] d, output int acc);
        int n = 0;
        acc = -1;
        if (p == 0) begin req0_valid = 1; req0_rs = r; req0_data = d; end
        else        begin req1_valid = 1; req1_rs = r; req1_data = d; end
        while (acc < 0 && n < BUDGET) begin
            @(negedge clk);
            if ((p == 0 ? req0_ready : req1_ready) === 1'b1) acc = now;
            n++;
        end
        chk("send_accepted", acc >= 0, 1'b1);
        @(posedge clk);
        #1;
        if (p == 0) begin req0_valid = 0; req0_data = 8'($urandom); end
        else        begin req1_valid = 0; req1_data = 8'($urandom); end
    endtask

    task automatic wait_init();
        int n = 0;
        while (init_done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("init_done_seen", init_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic random_port(input int p, input int count);
        int a;
        for (int i = 0; i < count; i++) begin
            logic       r;
            logic [7:0] d;
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #1;
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send(p, r, d, a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, base;
        rst = 1;
        req0_valid = 0; req0_rs = 0; req0_data = 8'h00;
        req1_valid = 0; req1_rs = 0; req1_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b1);
        chk("reset_init_done", init_done, 1'b0);
        chk("reset_en", en, 1'b0);
        rst = 0;

        // Power-up and init sequence with no requests.
        wait_init();
        chk("first_en_rise", first_rise, TP + 1 + TS);
        chk("init_done_cycle", init_done_cyc, 118);
        chk("model_init_end", m_F, 118);
        chk("init_pulses", pulse_cnt, 4);

        // Single data write on port 1, then a second to time the ready gap.
        send(1, 1'b1, 8'h32, a1);
        repeat (4) @(negedge clk);
        chk("t2_en_latency", last_rise - a1, 3);
        send(1, 1'b1, 8'h41, a2);
        chk("t2_ready_gap", a2 - a1, 17);

        // Both ports contending: grants must alternate starting with port 0.
        base = acc_port_q.size();
        fork
            begin
                int a;
                for (int i = 0; i < 4; i++) send(0, 1'b1, 8'h10 + 8'(i), a);
            end
            begin
                int a;
                for (int i = 0; i < 4; i++) send(1, 1'b1, 8'h20 + 8'(i), a);
            end
        join
        for (int i = 0; i < 8; i++) chk("t3_grant_order", acc_port_q[base + i], i % 2);

        // Clear command gets the long wait, the following command the short one.
        send(0, 1'b0, 8'h01, a1);
        send(0, 1'b0, 8'h0C, a2);
        send(0, 1'b1, 8'h80, a3);
        chk("t4_clear_gap", a2 - a1, 47);
        chk("t4_cmd_gap", a3 - a2, 17);

        // Reset in the middle of an en pulse.
        send(1, 1'b1, 8'h55, a1);
        a2 = 0;
        while (en !== 1'b1 && a2 < 20) begin
            @(negedge clk);
            a2++;
        end
        chk("t5_en_seen", en, 1'b1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("t5_en_dropped", en, 1'b0);
        chk("t5_init_cleared", init_done, 1'b0);
        rst = 0;

        // Request pending through the whole replayed init.
        send(0, 1'b1, 8'hA5, a1);
        chk("t6_accept_cycle", a1, 118);
        chk("t6_init_pulses", pulse_cnt, 4);

        // Randomised traffic on both ports.
        fork
            random_port(0, 12);
            random_port(1, 12);
        join
        repeat (80) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
